// File: rtl/tmr_y_voter.sv
// Majority voter for three replica copies of the packed result word, with a
// single-entry valid/ready output register and per-replica fault accounting.
`timescale 1ns/1ps
module tmr_y_voter #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y_a,
  input  logic [WIDTH-1:0] y_b,
  input  logic [WIDTH-1:0] y_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_err,
  output logic [1:0]       out_bad,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c,
  output logic             fatal
);

  logic [WIDTH-1:0] vote;
  logic [2:0]       fault;
  logic             multi_fault;
  logic             accept;
  logic [1:0]       bad;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             err_q, err_d;
  logic [1:0]       bad_q, bad_d;
  logic             fatal_q, fatal_d;
  logic [CNT_W-1:0] cnt_all [3];

  assign vote        = (y_a & y_b) | (y_a & y_c) | (y_b & y_c);
  assign fault       = {y_c != vote, y_b != vote, y_a != vote};
  assign multi_fault = (fault[0] & fault[1]) | (fault[0] & fault[2]) | (fault[1] & fault[2]);
  assign in_ready    = !valid_q || out_ready;
  assign accept      = in_valid && in_ready;

  // Any pattern with more than one faulty replica collapses onto code 3.
  always_comb begin
    case (fault)
      3'b000:  bad = 2'd0;
      3'b001:  bad = 2'd1;
      3'b010:  bad = 2'd2;
      default: bad = 2'd3;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    y_d     = y_q;
    err_d   = err_q;
    bad_d   = bad_q;
    fatal_d = fatal_q;
    if (accept) begin
      valid_d = 1'b1;
      y_d     = vote;
      err_d   = |fault;
      bad_d   = bad;
      fatal_d = fatal_q | multi_fault;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      err_q   <= 1'b0;
      bad_q   <= 2'd0;
      fatal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
      fatal_q <= fatal_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Saturate at all-ones rather than wrapping.
      always_comb begin
        cnt_d = cnt_q;
        if (accept && fault[gi] && (cnt_q != {CNT_W{1'b1}}))
          cnt_d = cnt_q + CNT_W'(1);
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign cnt_all[gi] = cnt_q;
    end
  endgenerate

  assign out_valid = valid_q;
  assign out_y     = y_q;
  assign out_err   = err_q;
  assign out_bad   = bad_q;
  assign fatal     = fatal_q;
  assign err_cnt_a = cnt_all[0];
  assign err_cnt_b = cnt_all[1];
  assign err_cnt_c = cnt_all[2];

endmodule

// File: tb/tb_tmr_y_voter.sv
// Directed bench for tmr_y_voter: a behavioural scoreboard checked every cycle
// plus literal expectations at key points of each scenario.
`timescale 1ns/1ps
module tb_tmr_y_voter;
  localparam int W    = 12;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  y_a = '0, y_b = '0, y_c = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_y;
  logic          out_err;
  logic [1:0]    out_bad;
  logic [CW-1:0] err_cnt_a, err_cnt_b, err_cnt_c;
  logic          fatal;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  tmr_y_voter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .y_a(y_a), .y_b(y_b), .y_c(y_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_err(out_err), .out_bad(out_bad),
    .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c),
    .fatal(fatal)
  );

  always #5 clk = ~clk;

  // Scoreboard state, derived from the behavioural rules only.
  bit         m_valid = 1'b0;
  bit [W-1:0] m_y     = '0;
  bit         m_err   = 1'b0;
  int         m_bad   = 0;
  int         m_cnt [3] = '{0, 0, 0};
  bit         m_fatal = 1'b0;

  function automatic bit [W-1:0] vote_of(input bit [W-1:0] a, b, c);
    bit [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  always @(posedge clk) begin
    bit [W-1:0] v;
    bit [2:0]   f;
    int         nf;
    if (rst) begin
      m_valid <= 1'b0; m_y <= '0; m_err <= 1'b0; m_bad <= 0;
      m_cnt   <= '{0, 0, 0}; m_fatal <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      v  = vote_of(y_a, y_b, y_c);
      f  = {y_c != v, y_b != v, y_a != v};
      nf = int'(f[0]) + int'(f[1]) + int'(f[2]);
      m_valid <= 1'b1;
      m_y     <= v;
      m_err   <= nf > 0;
      m_bad   <= (nf == 0) ? 0 : (nf >= 2) ? 3 : f[0] ? 1 : f[1] ? 2 : 3;
      for (int k = 0; k < 3; k++)
        if (f[k] && m_cnt[k] < CMAX) m_cnt[k] <= m_cnt[k] + 1;
      if (nf >= 2) m_fatal <= 1'b1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_in_ready",  32'(in_ready),  32'(!m_valid || out_ready));
      check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      check("cyc_out_y",     32'(out_y),     32'(m_y));
      check("cyc_out_err",   32'(out_err),   32'(m_err));
      check("cyc_out_bad",   32'(out_bad),   32'(m_bad));
      check("cyc_cnt_a",     32'(err_cnt_a), 32'(m_cnt[0]));
      check("cyc_cnt_b",     32'(err_cnt_b), 32'(m_cnt[1]));
      check("cyc_cnt_c",     32'(err_cnt_c), 32'(m_cnt[2]));
      check("cyc_fatal",     32'(fatal),     32'(m_fatal));
    end
  end

  task automatic step(input logic r, input logic v, input logic [W-1:0] a, b, c,
                      input logic ordy);
    rst = r; in_valid = v; y_a = a; y_b = b; y_c = c; out_ready = ordy;
    @(posedge clk);
    #1;
    $display("txn rst=%0b vld=%0b a=%03h b=%03h c=%03h ordy=%0b -> ov=%0b y=%03h err=%0b bad=%0d cnt=%0d/%0d/%0d fatal=%0b",
             r, v, a, b, c, ordy, out_valid, out_y, out_err, out_bad,
             err_cnt_a, err_cnt_b, err_cnt_c, fatal);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    step(1'b1, 1'b0, 12'h000, 12'h000, 12'h000, 1'b0);
    chk_en = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_y",     32'(out_y),     32'd0);
    check("rst_fatal", 32'(fatal),     32'd0);

    step(1'b0, 1'b1, 12'hA5C, 12'hA5C, 12'hA5C, 1'b1);
    check("clean_valid", 32'(out_valid), 32'd1);
    check("clean_y",     32'(out_y),     32'hA5C);
    check("clean_err",   32'(out_err),   32'd0);
    check("clean_bad",   32'(out_bad),   32'd0);

    step(1'b0, 1'b1, 12'h001, 12'h000, 12'h000, 1'b1);
    check("single_y",     32'(out_y),     32'h000);
    check("single_err",   32'(out_err),   32'd1);
    check("single_bad",   32'(out_bad),   32'd1);
    check("single_cnt_a", 32'(err_cnt_a), 32'd1);
    check("single_fatal", 32'(fatal),     32'd0);

    step(1'b0, 1'b1, 12'hF00, 12'h0F0, 12'h00F, 1'b1);
    check("multi_y",     32'(out_y),     32'h000);
    check("multi_bad",   32'(out_bad),   32'd3);
    check("multi_cnt_a", 32'(err_cnt_a), 32'd2);
    check("multi_cnt_b", 32'(err_cnt_b), 32'd1);
    check("multi_cnt_c", 32'(err_cnt_c), 32'd1);
    check("multi_fatal", 32'(fatal),     32'd1);

    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 12'h123, 12'h123, 12'h123, 1'b1);
    check("fatal_sticky", 32'(fatal),   32'd1);
    check("clean2_err",   32'(out_err), 32'd0);

    // Drain, then hold one word under backpressure while a second waits.
    step(1'b0, 1'b0, 12'hFFF, 12'h000, 12'hABC, 1'b1);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold_y", 32'(out_y),    32'h123);
    step(1'b0, 1'b1, 12'h111, 12'h111, 12'h110, 1'b0);
    check("bp1_y",     32'(out_y),     32'h111);
    check("bp1_bad",   32'(out_bad),   32'd3);
    check("bp1_cnt_c", 32'(err_cnt_c), 32'd2);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 12'h223, 12'h222, 12'h222, 1'b0);
      check("bp_hold_y",     32'(out_y),     32'h111);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
      check("bp_hold_cnt_a", 32'(err_cnt_a), 32'd2);
    end
    step(1'b0, 1'b1, 12'h223, 12'h222, 12'h222, 1'b1);
    check("bp2_valid", 32'(out_valid), 32'd1);
    check("bp2_y",     32'(out_y),     32'h222);
    check("bp2_bad",   32'(out_bad),   32'd1);
    check("bp2_cnt_a", 32'(err_cnt_a), 32'd3);

    step(1'b1, 1'b0, 12'h000, 12'h000, 12'h000, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 12'h0F0, 12'h0F1, 12'h0F0, 1'b1);
    check("sat_cnt_b", 32'(err_cnt_b), 32'd15);
    check("sat_cnt_a", 32'(err_cnt_a), 32'd0);
    check("sat_cnt_c", 32'(err_cnt_c), 32'd0);
    check("sat_bad",   32'(out_bad),   32'd2);
    check("sat_fatal", 32'(fatal),     32'd0);

    step(1'b1, 1'b1, 12'h777, 12'h770, 12'h007, 1'b1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_y",     32'(out_y),     32'd0);
    check("midrst_cnt_b", 32'(err_cnt_b), 32'd0);
    check("midrst_fatal", 32'(fatal),     32'd0);
    step(1'b0, 1'b0, 12'h777, 12'h770, 12'h007, 1'b1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_y",     32'(out_y),     32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
